// File: rtl/set_assoc_read_cache_if.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_read_cache_if
// Brief    : Client request/response and Muskbus read-port signal bundle.
// Revision : 1.0
// ============================================================================
interface set_assoc_read_cache_if;
    logic         reqcyc;
    logic [63:0]  addr;
    logic         respcyc;
    logic [0:511] rd_data;
    logic         bus_reqcyc;
    logic         bus_reqack;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_respcyc;
    logic         bus_respack;
    logic [63:0]  bus_resp;
    logic [12:0]  bus_resptag;

    // Environment side: client plus memory port.
    modport master (
        output reqcyc, addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  respcyc, rd_data, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    // Cache side.
    modport slave (
        input  reqcyc, addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output respcyc, rd_data, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface
`default_nettype wire

// File: rtl/set_assoc_read_cache.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_read_cache
// Brief    : Read-only set-associative cache of 64-byte lines, filled by
//            8-beat Muskbus read bursts, returning whole lines in one pulse.
// Revision : 1.0
// ============================================================================
module set_assoc_read_cache #(
    parameter int WAYS = 2,
    parameter int SETS = 64
) (
    input  wire logic             clk,
    input  wire logic             reset,
    set_assoc_read_cache_if.slave cif
);
    localparam int          c_IDX_W        = $clog2(SETS);
    localparam int          c_TAG_W        = 58 - c_IDX_W;
    localparam int          c_WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [12:0] c_READ_MEM_TAG = 13'h1100;

    localparam logic [1:0] c_S_IDLE      = 2'd0;
    localparam logic [1:0] c_S_MISS_REQ  = 2'd1;
    localparam logic [1:0] c_S_MISS_FILL = 2'd2;
    localparam logic [1:0] c_S_RESP      = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [57:0]        r_line_addr;
    logic [2:0]         r_beat;
    logic [0:511]       r_line;
    logic [0:511]       w_line_next;
    logic               r_valid [SETS][WAYS];
    logic [c_TAG_W-1:0] r_tag   [SETS][WAYS];
    logic [0:511]       r_data  [SETS][WAYS];
    logic [c_WAY_W-1:0] r_rr    [SETS];

    logic [c_IDX_W-1:0] w_req_idx;
    logic [c_TAG_W-1:0] w_req_tag;
    logic [c_IDX_W-1:0] w_fill_idx;
    logic [c_TAG_W-1:0] w_fill_tag;
    logic               w_hit;
    logic [0:511]       w_hit_data;
    logic [c_WAY_W-1:0] w_victim;
    logic               w_fill_last;
    logic               w_unused;

    assign w_req_idx  = cif.addr[6 +: c_IDX_W];
    assign w_req_tag  = cif.addr[63 -: c_TAG_W];
    assign w_fill_idx = r_line_addr[0 +: c_IDX_W];
    assign w_fill_tag = r_line_addr[57 -: c_TAG_W];
    assign w_unused   = ^{cif.addr[5:0], cif.bus_resptag};

    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_req_idx][w];
            end
        end
    end

    // Descending scan so the lowest-index invalid way wins over the pointer.
    always_comb begin
        w_victim = r_rr[w_fill_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_fill_idx][w]) begin
                w_victim = c_WAY_W'(w);
            end
        end
    end

    // Byte k of the current beat lands at line byte 8*beat + k.
    always_comb begin
        w_line_next = r_line;
        for (int k = 0; k < 8; k++) begin
            w_line_next[(int'(r_beat) * 8 + k) * 8 +: 8] = cif.bus_resp[k * 8 +: 8];
        end
    end

    assign w_fill_last = (r_state == c_S_MISS_FILL) && cif.bus_respcyc && (r_beat == 3'd7);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (cif.reqcyc) begin
                    w_state_next = w_hit ? c_S_RESP : c_S_MISS_REQ;
                end
            end
            c_S_MISS_REQ: begin
                if (cif.bus_reqack) begin
                    w_state_next = c_S_MISS_FILL;
                end
            end
            c_S_MISS_FILL: begin
                if (w_fill_last) begin
                    w_state_next = c_S_RESP;
                end
            end
            c_S_RESP: w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign cif.respcyc     = (r_state == c_S_RESP);
    assign cif.bus_reqcyc  = (r_state == c_S_MISS_REQ);
    assign cif.bus_req     = (r_state == c_S_MISS_REQ) ? {r_line_addr, 6'b0} : 64'd0;
    assign cif.bus_reqtag  = (r_state == c_S_MISS_REQ) ? c_READ_MEM_TAG : 13'd0;
    assign cif.bus_respack = (r_state == c_S_MISS_FILL) && cif.bus_respcyc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_addr <= '0;
            r_beat      <= '0;
            r_line      <= '0;
            cif.rd_data <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                end
            end
        end else begin
            if ((r_state == c_S_IDLE) && cif.reqcyc) begin
                r_line_addr <= cif.addr[63:6];
                if (w_hit) begin
                    cif.rd_data <= w_hit_data;
                end
            end
            if ((r_state == c_S_MISS_FILL) && cif.bus_respcyc) begin
                r_line <= w_line_next;
                r_beat <= r_beat + 3'd1;
            end
            if (w_fill_last) begin
                r_valid[w_fill_idx][w_victim] <= 1'b1;
                r_rr[w_fill_idx] <= (r_rr[w_fill_idx] == c_WAY_W'(WAYS - 1)) ? '0
                                  : r_rr[w_fill_idx] + 1'b1;
                cif.rd_data <= w_line_next;
            end
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill_last) begin
            r_tag[w_fill_idx][w_victim]  <= w_fill_tag;
            r_data[w_fill_idx][w_victim] <= w_line_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_set_assoc_read_cache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_set_assoc_read_cache
// Brief    : Self-checking bench for set_assoc_read_cache with a line-level
//            cache/memory reference model and a Muskbus responder.
// Revision : 1.0
// ============================================================================
module tb_set_assoc_read_cache;
    localparam int          WAYS  = 2;
    localparam int          SETS  = 64;
    localparam logic [12:0] c_TAG = 13'h1100;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [511:0] mem [logic [63:0]];
    logic [511:0] seed_line;
    bit           m_valid [SETS][WAYS];
    logic [63:0]  m_line  [SETS][WAYS];
    int           m_ptr   [SETS];

    set_assoc_read_cache_if cif();

    set_assoc_read_cache #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    function automatic int set_of(logic [63:0] a);
        return int'((a >> 6) % 64'(SETS));
    endfunction

    function automatic bit model_hit(logic [63:0] a);
        int s = set_of(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_line[s][w] == {a[63:6], 6'b0}) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_fill(logic [63:0] a);
        int s = set_of(a);
        int v = -1;
        for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[s][w]) v = w;
        if (v < 0) v = m_ptr[s];
        m_valid[s][v] = 1'b1;
        m_line[s][v]  = {a[63:6], 6'b0};
        m_ptr[s]      = (m_ptr[s] + 1) % WAYS;
    endfunction

    function automatic logic [511:0] get_line(logic [63:0] la);
        logic [511:0] v;
        if (!mem.exists(la)) begin
            for (int j = 0; j < 16; j++) v[j * 32 +: 32] = $urandom;
            mem[la] = v;
        end
        return mem[la];
    endfunction

    function automatic int first_bad_byte(logic [511:0] exp_line);
        for (int n = 0; n < 64; n++)
            if (cif.rd_data[n * 8 +: 8] !== exp_line[n * 8 +: 8]) return n;
        return -1;
    endfunction

    // One client request plus the memory side of any miss it causes.
    task automatic run_req(input logic [63:0] a, input int ack_delay, input int bubble_pct,
                           input int abort_beats, input bit keep, output bit was_miss);
        logic [63:0]  la;
        logic [511:0] exp_line;
        bit           exp_hit;
        bit           got_resp;
        int           phase;
        int           beats;
        int           wait_left;
        int           fb;
        la        = {a[63:6], 6'b0};
        exp_hit   = model_hit(a);
        exp_line  = get_line(la);
        phase     = 0;
        beats     = 0;
        wait_left = ack_delay;
        got_resp  = 1'b0;
        was_miss  = 1'b0;
        cif.addr   = a;
        cif.reqcyc = 1'b1;
        for (int cyc = 1; cyc <= 300 && !got_resp; cyc++) begin
            @(posedge clk); #1;
            if (abort_beats > 0 && beats == abort_beats) return;
            cif.bus_respcyc = 1'b0;
            if (cif.bus_reqcyc) was_miss = 1'b1;
            if (cyc == 1 && !exp_hit) begin
                checks++;
                if (cif.bus_reqcyc !== 1'b1) begin
                    failures++;
                    $display("FAIL miss_req_latency addr=%h got bus_reqcyc=%b want 1", a, cif.bus_reqcyc);
                end
            end
            if (cif.respcyc === 1'b1) begin
                got_resp = 1'b1;
                checks++;
                if (was_miss !== !exp_hit) begin
                    failures++;
                    $display("FAIL hit_miss addr=%h got miss=%b want miss=%b", a, was_miss, !exp_hit);
                end
                checks++;
                if (exp_hit ? (cyc != 1) : (beats != 8)) begin
                    failures++;
                    $display("FAIL resp_timing addr=%h got cycle=%0d beats=%0d want %s", a, cyc, beats,
                             exp_hit ? "cycle 1" : "8 beats");
                end
                fb = first_bad_byte(exp_line);
                checks++;
                if (fb >= 0) begin
                    failures++;
                    $display("FAIL rd_data addr=%h byte %0d got %h want %h", a, fb,
                             cif.rd_data[fb * 8 +: 8], exp_line[fb * 8 +: 8]);
                end
            end else begin
                if (phase == 0 && cif.bus_reqcyc === 1'b1) begin
                    checks++;
                    if (cif.bus_req !== la || cif.bus_reqtag !== c_TAG) begin
                        failures++;
                        $display("FAIL bus_request got req=%h tag=%h want req=%h tag=%h",
                                 cif.bus_req, cif.bus_reqtag, la, c_TAG);
                    end
                    if (wait_left == 0) begin
                        cif.bus_reqack = 1'b1;
                        phase = 1;
                    end else begin
                        wait_left--;
                    end
                end else if (phase == 1) begin
                    cif.bus_reqack = 1'b0;
                    checks++;
                    if (cif.bus_reqcyc !== 1'b0) begin
                        failures++;
                        $display("FAIL bus_reqcyc_drop got %b want 0", cif.bus_reqcyc);
                    end
                    phase = 2;
                end
                if (phase == 2) begin
                    if (beats < 8 && $urandom_range(0, 99) >= bubble_pct) begin
                        cif.bus_respcyc = 1'b1;
                        cif.bus_resp    = exp_line[beats * 64 +: 64];
                        beats++;
                    end else begin
                        cif.bus_resp = {$urandom, $urandom};
                    end
                    #1;
                    checks++;
                    if (cif.bus_respack !== cif.bus_respcyc) begin
                        failures++;
                        $display("FAIL bus_respack got %b want %b", cif.bus_respack, cif.bus_respcyc);
                    end
                end
            end
        end
        if (!got_resp) begin
            checks++;
            failures++;
            $display("FAIL timeout addr=%h got no respcyc want one", a);
            cif.reqcyc      = 1'b0;
            cif.bus_reqack  = 1'b0;
            cif.bus_respcyc = 1'b0;
            return;
        end
        if (!exp_hit) model_fill(a);
        if (!keep) cif.reqcyc = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cif.respcyc !== 1'b0) begin
            failures++;
            $display("FAIL resp_pulse addr=%h got respcyc=%b want 0", a, cif.respcyc);
        end
        fb = first_bad_byte(exp_line);
        checks++;
        if (fb >= 0) begin
            failures++;
            $display("FAIL rd_data_hold addr=%h byte %0d got %h want %h", a, fb,
                     cif.rd_data[fb * 8 +: 8], exp_line[fb * 8 +: 8]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cif.respcyc, cif.bus_reqcyc, cif.bus_respack} !== 3'b000 || cif.rd_data !== '0 ||
            cif.bus_req !== 64'd0 || cif.bus_reqtag !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got resp=%b reqcyc=%b respack=%b req=%h tag=%h want all 0",
                     cif.respcyc, cif.bus_reqcyc, cif.bus_respack, cif.bus_req, cif.bus_reqtag);
        end
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (cif.bus_reqcyc !== 1'b0 || cif.respcyc !== 1'b0) begin
                failures++;
                $display("FAIL idle_quiet got reqcyc=%b respcyc=%b want 0 0", cif.bus_reqcyc, cif.respcyc);
            end
        end
    endtask

    task automatic test_cold_miss();
        bit m;
        run_req(64'h1000, 3, 0, 0, 1'b0, m);
        checks++;
        if (m !== 1'b1 || cif.rd_data[0:7] !== 8'h00 || cif.rd_data[504:511] !== 8'h3f) begin
            failures++;
            $display("FAIL cold_miss got miss=%b byte0=%h byte63=%h want 1 00 3f",
                     m, cif.rd_data[0:7], cif.rd_data[504:511]);
        end
    endtask

    task automatic test_hits();
        bit m;
        run_req(64'h1000, 0, 0, 0, 1'b0, m);
        checks++;
        if (m !== 1'b0) begin
            failures++;
            $display("FAIL hit_1000 got miss=%b want 0", m);
        end
        run_req(64'h1025, 0, 0, 0, 1'b0, m);
        checks++;
        if (m !== 1'b0 || cif.rd_data[40:47] !== 8'h05) begin
            failures++;
            $display("FAIL hit_1025 got miss=%b byte5=%h want 0 05", m, cif.rd_data[40:47]);
        end
    endtask

    task automatic test_conflict();
        bit m1, m2, m3, m4;
        run_req(64'h3000, 1, 0, 0, 1'b0, m1);
        run_req(64'h5000, 0, 0, 0, 1'b0, m2);
        run_req(64'h3000, 0, 0, 0, 1'b0, m3);
        run_req(64'h1000, 2, 0, 0, 1'b0, m4);
        checks++;
        if ({m1, m2, m3, m4} !== 4'b1101) begin
            failures++;
            $display("FAIL conflict got miss pattern=%b want 1101", {m1, m2, m3, m4});
        end
    endtask

    task automatic test_bubbles();
        bit m;
        run_req(64'h2040, 0, 50, 0, 1'b0, m);
        run_req(64'h62C0, 1, 70, 0, 1'b0, m);
        checks++;
        if (m !== 1'b1) begin
            failures++;
            $display("FAIL bubbles got miss=%b want 1", m);
        end
    endtask

    task automatic test_back_to_back();
        bit m1, m2;
        run_req(64'h1000, 0, 0, 0, 1'b1, m1);
        run_req(64'h1040, 0, 20, 0, 1'b0, m2);
        checks++;
        if ({m1, m2} !== 2'b01) begin
            failures++;
            $display("FAIL back_to_back got miss pattern=%b want 01", {m1, m2});
        end
    endtask

    task automatic test_reset_mid_fill();
        bit m;
        run_req(64'h9000, 0, 0, 4, 1'b0, m);
        reset = 1'b0;
        #1;
        checks++;
        if ({cif.respcyc, cif.bus_reqcyc, cif.bus_respack} !== 3'b000 || cif.rd_data !== '0 ||
            cif.bus_req !== 64'd0 || cif.bus_reqtag !== 13'd0) begin
            failures++;
            $display("FAIL reset_mid_fill got resp=%b reqcyc=%b respack=%b req=%h tag=%h want all 0",
                     cif.respcyc, cif.bus_reqcyc, cif.bus_respack, cif.bus_req, cif.bus_reqtag);
        end
        cif.bus_respcyc = 1'b0;
        cif.bus_reqack  = 1'b0;
        cif.reqcyc      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (cif.bus_reqcyc !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_quiet got bus_reqcyc=%b want 0", cif.bus_reqcyc);
            end
        end
        run_req(64'h9000, 1, 0, 0, 1'b0, m);
        checks++;
        if (m !== 1'b1) begin
            failures++;
            $display("FAIL refetch_9000 got miss=%b want 1", m);
        end
        run_req(64'h1000, 0, 0, 0, 1'b0, m);
        checks++;
        if (m !== 1'b1) begin
            failures++;
            $display("FAIL refetch_1000 got miss=%b want 1", m);
        end
    endtask

    task automatic test_random();
        bit          m;
        logic [63:0] a;
        int          t;
        for (int i = 0; i < 60; i++) begin
            t = $urandom_range(0, 3);
            a = (64'(t) << 12) | (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63));
            if (t == 3) a[63] = 1'b1;
            run_req(a, $urandom_range(0, 3), $urandom_range(0, 40), 0, 1'(($urandom_range(0, 3)) == 0), m);
        end
        cif.reqcyc = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        cif.reqcyc      = 1'b0;
        cif.addr        = 64'd0;
        cif.bus_reqack  = 1'b0;
        cif.bus_respcyc = 1'b0;
        cif.bus_resp    = 64'd0;
        cif.bus_resptag = 13'd0;
        for (int n = 0; n < 64; n++) seed_line[n * 8 +: 8] = 8'(n);
        mem[64'h1000] = seed_line;
        #2;
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/set_assoc_read_cache.md
Name: set_assoc_read_cache

Overview:
Read-only, set-associative cache of 64-byte lines. It sits between the instruction-fetch/decode-buffer logic and the Muskbus memory port. The client requests one line at a time; the block returns the whole line in one 512-bit pulse and fills misses with an 8-beat Muskbus read burst. The block never writes to memory.

Parameters:
WAYS, 2, associativity (power of two, ≥1)
SETS, 64, number of sets (power of two); default capacity is 8 KiB
LINE_BYTES, 64, line size; fixed, not overridable

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
reqcyc  in  1  client read request (level)
addr  in  64  client address; bits [5:0] ignored
respcyc  out  1  one-cycle pulse: rd_data valid
rd_data  out  512  line data, big-endian bit order [0:511]; byte n at bits [n*8 +: 8]
bus_reqcyc  out  1  Muskbus request valid
bus_reqack  in  1  Muskbus request accepted
bus_req  out  64  Muskbus request address (line aligned)
bus_reqtag  out  13  Muskbus request tag
bus_respcyc  in  1  Muskbus response beat valid
bus_respack  out  1  Muskbus response beat acknowledge
bus_resp  in  64  Muskbus response beat data
bus_resptag  in  13  response tag; unused

Behaviour:
- Address split: offset = addr[5:0] (ignored); index = addr[6 +: log2(SETS)]; tag = the remaining upper bits.
- State per way/set: valid bit, tag, 512-bit data. One round-robin victim pointer per set. All state is held in flops.
- Reset (async, while low): all valid bits = 0, victim pointers = 0, FSM = IDLE. Outputs respcyc = 0, rd_data = 0, bus_reqcyc = 0, bus_req = 0, bus_reqtag = 0, bus_respack = 0.
- Reset asserted mid-fill discards any partial line. The block issues no further bus traffic until the next request after reset is released.
- FSM states are IDLE, MISS_REQ, MISS_FILL and RESP.
- IDLE: reqcyc is sampled only in this state. When reqcyc = 1, latch the line address and compare the tag against all ways of the set combinationally.
  - On a hit: load rd_data from the hit way and go to RESP.
  - On a miss: go to MISS_REQ.
- MISS_REQ:
  - Drive bus_reqcyc = 1, bus_req = {addr[63:6], 6'b0} and bus_reqtag = 13'h1100 (bit 12 = READ, bits 11:8 = 4'b0001 MEMORY, bits 7:0 = 0).
  - Hold these values until bus_reqack = 1 is sampled, then drop bus_reqcyc and go to MISS_FILL.
- MISS_FILL:
  - bus_respack = bus_respcyc, combinationally.
  - Each beat with bus_respcyc = 1 is stored as beat i (i = 0..7).
  - Byte k of the beat (bus_resp[8k+7:8k]) becomes line byte 8i+k, i.e. bits [(8i+k)*8 +: 8] of the line.
  - Cycles without bus_respcyc wait.
  - After beat 7:
    - Victim: the lowest-index invalid way of the set if one exists, otherwise the round-robin pointer way.
    - Write the victim's data, tag and valid = 1; advance that set's pointer (mod WAYS).
    - Load rd_data with the line and go to RESP.
- RESP: respcyc = 1 for exactly one cycle with rd_data valid, then return to IDLE. reqcyc is ignored in RESP, because the client may still show the old request in that cycle.
- Latency:
  - Hit: reqcyc sampled at edge N, respcyc high in the cycle after edge N (one cycle).
  - Miss: bus_reqcyc rises the cycle after sampling; respcyc rises the cycle after beat 7 is captured.
- The client holds reqcyc and addr stable until respcyc. Changing them earlier is undefined.
- Back-to-back requests: the next request is sampled in the IDLE cycle following RESP.
- rd_data holds its value after respcyc until the next response.
- No coherence or invalidate port. Memory is assumed unmodified by others.

Test Plan:
- Cold miss to 0x1000: expect bus_req = 0x1000 and bus_reqtag = 0x1100; hold bus_reqack low 3 cycles, then high. Return beats 0x0706050403020100, 0x0F0E0D0C0B0A0908, ... up to 0x3F3E...38. Expect respcyc once, with rd_data byte n = n (rd_data[0:7] = 8'h00), and bus_respack mirroring bus_respcyc.
- Repeat 0x1000, then 0x1025: both hit; respcyc one cycle after reqcyc; bus_reqcyc stays 0; same data as the cold miss.
- Conflict, WAYS = 2, SETS = 64, addresses 0x1000, 0x3000, 0x5000 (all set 0): three misses. 0x5000 evicts 0x1000 via the round-robin pointer (way 0). A following 0x1000 misses and 0x3000 hits.
- Beats with bubbles (bus_respcyc low between beats): line assembled in order, no duplicate capture, respcyc only after the 8th beat.
- Client keeps reqcyc high during RESP and moves addr from 0x1000 to 0x1040 the cycle after: exactly one respcyc per address, second request handled correctly.
- Reset pulsed low after beat 3 of a fill: outputs go to 0 immediately. After release, a request to the same address misses (valid cleared) and issues a fresh bus request.
